// File: rtl/time_disp_drv.sv
// HH.MM.SS display driver: captures binary time on a strobe, converts each field to BCD
// by repeated subtraction, and scans six multiplexed 7-segment digits.
module time_disp_drv #(
    parameter int SCAN_DIV = 1000,
    parameter int HR_MAX   = 23,
    parameter bit ACT_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] sec_in,
    input  logic [5:0] min_in,
    input  logic [5:0] hr_in,
    input  logic       upd,
    output logic       busy,
    output logic       valid,
    output logic       err,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] an
);

    // state  | meaning
    // IDLE   | waiting for upd
    // CONV_S | converting seconds shadow to BCD
    // CONV_M | converting minutes shadow to BCD
    // CONV_H | converting hours shadow to BCD
    // COMMIT | publish all six digits, err and valid at once
    typedef enum logic [2:0] {IDLE, CONV_S, CONV_M, CONV_H, COMMIT} state_t;

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_TC = PW'(SCAN_DIV - 1);
    localparam logic [5:0]    HR_LIM   = 6'(HR_MAX);

    state_t          state;
    logic [5:0]      sh_s, sh_m, sh_h;
    logic [5:0]      w;
    logic [2:0]      t;
    logic            pend;
    logic            err_acc;
    logic [5:0][3:0] nd;
    logic [5:0][3:0] dig;
    logic [2:0]      idx;
    logic [PW-1:0]   presc;

    logic [5:0] field;
    logic [5:0] lim;
    logic       bad;
    logic       step_done;
    logic [3:0] ones;
    logic [3:0] tens;

    always_comb begin
        field = sh_s;
        lim   = 6'd59;
        case (state)
            CONV_M:  field = sh_m;
            CONV_H: begin
                field = sh_h;
                lim   = HR_LIM;
            end
            default: ;
        endcase
        bad       = field > lim;
        step_done = bad || (w < 6'd10);
        ones      = bad ? 4'hF : w[3:0];
        tens      = bad ? 4'hF : {1'b0, t};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            sh_s    <= '0;
            sh_m    <= '0;
            sh_h    <= '0;
            w       <= '0;
            t       <= '0;
            pend    <= 1'b0;
            err_acc <= 1'b0;
            nd      <= '0;
            dig     <= '0;
            busy    <= 1'b0;
            valid   <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (upd) begin
                        sh_s    <= sec_in;
                        sh_m    <= min_in;
                        sh_h    <= hr_in;
                        w       <= sec_in;
                        t       <= '0;
                        err_acc <= 1'b0;
                        busy    <= 1'b1;
                        state   <= CONV_S;
                    end
                end
                CONV_S, CONV_M, CONV_H: begin
                    if (upd)
                        pend <= 1'b1;
                    if (step_done) begin
                        t       <= '0;
                        err_acc <= err_acc | bad;
                        case (state)
                            CONV_S: begin
                                nd[0] <= ones;
                                nd[1] <= tens;
                                w     <= sh_m;
                                state <= CONV_M;
                            end
                            CONV_M: begin
                                nd[2] <= ones;
                                nd[3] <= tens;
                                w     <= sh_h;
                                state <= CONV_H;
                            end
                            default: begin
                                nd[4] <= ones;
                                nd[5] <= tens;
                                state <= COMMIT;
                            end
                        endcase
                    end else begin
                        w <= w - 6'd10;
                        t <= t + 3'd1;
                    end
                end
                COMMIT: begin
                    dig   <= nd;
                    err   <= err_acc;
                    valid <= 1'b1;
                    // a strobe landing on COMMIT is folded into the restart
                    if (pend || upd) begin
                        sh_s    <= sec_in;
                        sh_m    <= min_in;
                        sh_h    <= hr_in;
                        w       <= sec_in;
                        t       <= '0;
                        err_acc <= 1'b0;
                        pend    <= 1'b0;
                        state   <= CONV_S;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    function automatic logic [6:0] seg_dec(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hF:    s = 7'h40;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    logic [3:0] cur;
    logic       dp_on;

    always_comb begin
        case (idx)
            3'd0:    cur = dig[0];
            3'd1:    cur = dig[1];
            3'd2:    cur = dig[2];
            3'd3:    cur = dig[3];
            3'd4:    cur = dig[4];
            default: cur = dig[5];
        endcase
        dp_on = (idx == 3'd2) || (idx == 3'd4);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc <= '0;
            idx   <= '0;
            an    <= {6{ACT_LOW}};
            seg   <= {7{ACT_LOW}};
            dp    <= ACT_LOW;
        end else begin
            if (presc == PRESC_TC) begin
                presc <= '0;
                idx   <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            end else begin
                presc <= presc + PW'(1);
            end
            if (valid) begin
                an  <= (6'd1 << idx) ^ {6{ACT_LOW}};
                seg <= seg_dec(cur) ^ {7{ACT_LOW}};
                dp  <= dp_on ^ ACT_LOW;
            end else begin
                an  <= {6{ACT_LOW}};
                seg <= {7{ACT_LOW}};
                dp  <= ACT_LOW;
            end
        end
    end

endmodule

// File: tb/tb_time_disp_drv.sv
// Bench for time_disp_drv: conversion vector table with a scoreboard queue, plus
// hand sequences for scan timing, back-to-back strobes and reset mid-conversion.
module tb_time_disp_drv;

    logic       clk;
    logic       rst;
    logic [5:0] sec_in, min_in, hr_in;
    logic       upd;
    logic       busy, valid, err;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] an;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [5:0]      s;
        logic [5:0]      m;
        logic [5:0]      h;
        logic [23:0]     d;
        logic            e;
        int              cyc;
    } vec_t;

    vec_t vecs[7];
    vec_t sb[$];

    time_disp_drv #(.SCAN_DIV(4), .HR_MAX(23), .ACT_LOW(1'b1)) dut (
        .clk(clk), .rst(rst),
        .sec_in(sec_in), .min_in(min_in), .hr_in(hr_in),
        .upd(upd), .busy(busy), .valid(valid), .err(err),
        .seg(seg), .dp(dp), .an(an)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] exp_seg(input logic [3:0] d);
        logic [6:0] h;
        case (d)
            4'h0: h = 7'h3F;  4'h1: h = 7'h06;  4'h2: h = 7'h5B;  4'h3: h = 7'h4F;
            4'h4: h = 7'h66;  4'h5: h = 7'h6D;  4'h6: h = 7'h7D;  4'h7: h = 7'h07;
            4'h8: h = 7'h7F;  4'h9: h = 7'h6F;  4'hF: h = 7'h40;
            default: h = 7'h00;
        endcase
        return ~h;
    endfunction

    task automatic do_upd(input logic [5:0] s, input logic [5:0] m, input logic [5:0] h);
        sec_in = s; min_in = m; hr_in = h; upd = 1'b1;
        @(negedge clk);
        upd = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic check_blank(input string tag);
        chk({tag, "_an"}, 32'(an), 32'h3F);
        chk({tag, "_seg"}, 32'(seg), 32'h7F);
        chk({tag, "_dp"}, 32'(dp), 32'h1);
    endtask

    task automatic check_display(input logic [23:0] d);
        logic [5:0] want;
        logic [3:0] dg;
        int         n;
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            want = ~(6'd1 << k);
            n = 0;
            while (an !== want && n < 60) begin
                n++;
                @(negedge clk);
            end
            chk($sformatf("disp_reach_idx%0d", k), 32'(an), 32'(want));
            dg = d[k*4 +: 4];
            chk($sformatf("disp_seg_idx%0d", k), 32'(seg), 32'(exp_seg(dg)));
            chk($sformatf("disp_dp_idx%0d", k), 32'(dp), (k == 2 || k == 4) ? 32'h0 : 32'h1);
        end
    endtask

    task automatic check_scan(input logic [23:0] d);
        logic [5:0] want;
        int         n;
        n = 0;
        while (an !== 6'b011111 && n < 60) begin n++; @(negedge clk); end
        n = 0;
        while (an === 6'b011111 && n < 60) begin n++; @(negedge clk); end
        chk("scan_sync", 32'(an), 32'h3E);
        for (int k = 0; k < 6; k++) begin
            want = ~(6'd1 << k);
            for (int c = 0; c < 4; c++) begin
                chk($sformatf("scan_an_k%0d_c%0d", k, c), 32'(an), 32'(want));
                chk($sformatf("scan_seg_k%0d_c%0d", k, c), 32'(seg), 32'(exp_seg(d[k*4 +: 4])));
                chk($sformatf("scan_dp_k%0d_c%0d", k, c), 32'(dp), (k == 2 || k == 4) ? 32'h0 : 32'h1);
                @(negedge clk);
            end
        end
        chk("scan_wrap", 32'(an), 32'h3E);
    endtask

    initial begin
        vec_t v;
        int   nb;

        vecs[0] = '{6'd59, 6'd7,  6'd23, 24'h230759, 1'b0, 11};
        vecs[1] = '{6'd60, 6'd0,  6'd24, 24'hFF00FF, 1'b1, 4};
        vecs[2] = '{6'd0,  6'd0,  6'd0,  24'h000000, 1'b0, 4};
        vecs[3] = '{6'd45, 6'd38, 6'd12, 24'h123845, 1'b0, 12};
        vecs[4] = '{6'd9,  6'd59, 6'd63, 24'hFF5909, 1'b1, 9};
        vecs[5] = '{6'd10, 6'd60, 6'd9,  24'h09FF10, 1'b1, 5};
        vecs[6] = '{6'd33, 6'd21, 6'd20, 24'h202133, 1'b0, 11};

        rst = 1'b0; upd = 1'b0; sec_in = '0; min_in = '0; hr_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_blank("reset");
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_valid", 32'(valid), 32'h0);
        chk("reset_err", 32'(err), 32'h0);
        repeat (10) @(negedge clk);
        check_blank("blank_prevalid");

        for (int i = 0; i < 7; i++) begin
            do_upd(vecs[i].s, vecs[i].m, vecs[i].h);
            sb.push_back(vecs[i]);
            count_busy(nb);
            v = sb.pop_front();
            chk($sformatf("vec%0d_busy_cycles", i), 32'(nb), 32'(v.cyc));
            chk($sformatf("vec%0d_err", i), 32'(err), 32'(v.e));
            chk($sformatf("vec%0d_valid", i), 32'(valid), 32'h1);
            check_display(v.d);
            if (i == 0)
                check_scan(v.d);
        end

        // second strobe during busy: collapses into one restart after COMMIT
        do_upd(6'd10, 6'd0, 6'd0);
        sb.push_back('{6'd11, 6'd0, 6'd0, 24'h000011, 1'b0, 10});
        nb = 0;
        while (busy === 1'b1 && nb < 200) begin
            nb++;
            if (nb == 2) begin sec_in = 6'd11; upd = 1'b1; end
            else upd = 1'b0;
            @(negedge clk);
        end
        upd = 1'b0;
        v = sb.pop_front();
        chk("b2b_busy_run", 32'(nb), 32'(v.cyc));
        chk("b2b_err", 32'(err), 32'(v.e));
        check_display(v.d);

        // strobe exactly on the COMMIT cycle
        do_upd(6'd0, 6'd0, 6'd0);
        sb.push_back('{6'd5, 6'd0, 6'd0, 24'h000005, 1'b0, 8});
        nb = 0;
        while (busy === 1'b1 && nb < 200) begin
            nb++;
            if (nb == 4) begin sec_in = 6'd5; upd = 1'b1; end
            else upd = 1'b0;
            @(negedge clk);
        end
        upd = 1'b0;
        v = sb.pop_front();
        chk("commit_upd_busy_run", 32'(nb), 32'(v.cyc));
        check_display(v.d);

        // reset during CONV_M
        do_upd(6'd59, 6'd59, 6'd23);
        repeat (6) @(negedge clk);
        rst = 1'b0;
        #1;
        check_blank("midreset");
        chk("midreset_busy", 32'(busy), 32'h0);
        chk("midreset_valid", 32'(valid), 32'h0);
        chk("midreset_err", 32'(err), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_blank("postreset");
        chk("postreset_busy", 32'(busy), 32'h0);

        do_upd(6'd1, 6'd2, 6'd3);
        sb.push_back('{6'd1, 6'd2, 6'd3, 24'h030201, 1'b0, 4});
        count_busy(nb);
        v = sb.pop_front();
        chk("restart_busy_cycles", 32'(nb), 32'(v.cyc));
        chk("restart_valid", 32'(valid), 32'h1);
        chk("restart_err", 32'(err), 32'(v.e));
        check_display(v.d);
        repeat (5) @(negedge clk);
        chk("restart_idle", 32'(busy), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/time_disp_drv.md
Name: time_disp_drv

Overview:
- Downstream consumer of the seconds/minutes/hours counter.
- Samples the counter's binary sec/min/hr values on an update strobe and converts each field to two BCD digits with a sequential repeated-subtract converter.
- Drives a 6-digit time-multiplexed 7-segment display (HH.MM.SS) with a programmable scan rate.
- Sits between the clock counter and the board's display pins.

Parameters:
- SCAN_DIV, 1000: clk cycles each digit stays enabled; legal range ≥2.
- HR_MAX, 23: largest legal hour value; larger values are flagged as errors.
- ACT_LOW, 1: 1 = segment, anode and dp outputs are active-low; 0 = active-high.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous active-low reset.
- sec_in  in  6  binary seconds from the counter.
- min_in  in  6  binary minutes from the counter.
- hr_in  in  6  binary hours from the counter.
- upd  in  1  one-cycle strobe requesting capture of sec_in/min_in/hr_in.
- busy  out  1  conversion in progress.
- valid  out  1  at least one conversion has committed since reset.
- err  out  1  last committed capture had an out-of-range field.
- seg  out  7  segments {g,f,e,d,c,b,a}, polarity set by ACT_LOW.
- dp  out  1  decimal point, polarity set by ACT_LOW.
- an  out  6  digit enables, one-hot, polarity set by ACT_LOW.

Behaviour:
- Clocking and reset: one clock domain. Reset is asynchronous and active-low (rst=0 resets immediately; release is synchronous to clk).
- Reset values:
  - FSM=IDLE; busy=0, valid=0, err=0, pend=0.
  - Digit registers all 0; scan index 0; prescaler 0.
  - an, seg and dp all inactive (blank).
- Blanking: while valid=0, an, seg and dp stay inactive.
- FSM states: IDLE, CONV_S, CONV_M, CONV_H, COMMIT.
- IDLE: when upd=1 is sampled, capture the three inputs into shadow registers and go to CONV_S.
- CONV_x (working register w, tens counter t):
  - Load w with the field and clear t on entry.
  - Each cycle: if w≥10, then w -= 10 and t += 1; otherwise record ones=w[3:0], tens=t, and move to the next state.
  - Each field therefore takes tens+1 cycles (max 6 cycles for 59).
- Range check:
  - sec or min > 59, or hr > HR_MAX: both digits of that field become code 4'hF (dash), and the skip takes 1 cycle.
  - The err flag for the capture is the OR over the three fields.
- COMMIT:
  - All six digit registers, err and valid=1 update together in this single cycle, so no partial update is ever visible.
  - Then go to IDLE, or to CONV_S if pend=1 (pend cleared, inputs re-captured this cycle).
- busy: 1 in every CONV_x and COMMIT cycle, 0 in IDLE.
- Latency: upd sampled at cycle 0; busy=1 from cycle 1; total busy cycles = (ts+1)+(tm+1)+(th+1)+1; new digits are visible from the cycle after COMMIT.
- upd while busy: sets pend (not queued deeper; multiple strobes collapse into one). upd in the same cycle as COMMIT also sets pend.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1. At the terminal count the index advances 0→1→…→5→0 (wrap) and the prescaler returns to 0.
  - Digit mapping: 0 = sec ones, 1 = sec tens, 2 = min ones, 3 = min tens, 4 = hr ones, 5 = hr tens.
  - an[index] is active and all other enables inactive.
  - dp is active on indices 2 and 4 only.
  - Scan runs continuously, independent of the FSM.
- Segment decode ({g..a}, active-high form; inverted when ACT_LOW=1):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, F=40 (dash).
  - Codes A–E blank.
- Outputs: seg, dp and an are registered, so the display lags the scan index by one cycle.
- Reset mid-conversion: aborts the conversion, restores all reset values and blanks the display; the pending request is lost.

Test Plan:
1. Reset: rst=0 for 3 cycles, then release → an=6'h3F, seg=7'h7F, dp=1, busy=0, valid=0, err=0 (ACT_LOW=1).
2. Conversion: sec=59, min=7, hr=23, upd pulse → busy high for exactly 6+1+3+1=11 cycles. Digits then read 9,5,7,0,3,2 (indices 0–5), valid=1, err=0.
3. Scan: SCAN_DIV=4 after test 2 → each an bit is low for 4 cycles in order 0..5, then wraps to 0.
   - seg sequence is 7'h10, 7'h12, 7'h78, 7'h40, 7'h30, 7'h24.
   - dp is low only on indices 2 and 4.
4. Out-of-range: sec=60, min=0, hr=24 → err=1; digits 0, 1, 4 and 5 show 7'h3F (dash, active-low); min shows "00".
5. Back-to-back requests: upd with 00:00:10, then a second upd during busy with 00:00:11 → second conversion starts in the cycle after COMMIT; final digits show 11; busy never drops between the two conversions.
6. Reset mid-conversion: assert rst=0 during CONV_M → outputs blank immediately, busy=0, valid=0; after release, upd restarts cleanly.
